// File: rtl/mult_ctrl.sv
// Shift-and-add multiplier sequencer: Moore FSM with a shadow iteration counter and a sticky overrun flag.
// Optional early termination on an all-zero multiplier is enabled by defining MULT_CTRL_SKIP_EN.
module mult_ctrl #(
  parameter int ITERS = 4,
  parameter int CW    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic cnt_done,
  input  logic b_zero,
  output logic ld,
  output logic clr_p,
  output logic add_en,
  output logic shift_en,
  output logic dc,
  output logic busy,
  output logic done,
  output logic err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TEST,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] SC_MAX  = '1;
  localparam logic [CW-1:0] SC_OVER = CW'(ITERS + 1);

  state_t        state, next;
  logic [CW-1:0] sc;
  logic          overrun;
  logic          skip;

  // The shadow counter only disagrees with the datapath counter when cnt_done never arrives.
  assign overrun = (state == S_TEST) && !cnt_done && (sc == SC_OVER);

`ifdef MULT_CTRL_SKIP_EN
  assign skip = b_zero;
`else
  logic unused_b_zero;
  assign unused_b_zero = b_zero;
  assign skip          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
    if (rst) begin
      state <= S_IDLE;
      sc    <= '0;
      err   <= 1'b0;
    end else begin
      state <= next;
      // Clearing on entry keeps err visible right up to the first LOAD cycle of the next operation.
      if (state == S_IDLE && start) begin
        sc  <= '0;
        err <= 1'b0;
      end else begin
        if (state == S_SHIFT && sc != SC_MAX) sc <= sc + 1'b1;
        if (overrun) err <= 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latches).
    next     = state;
    ld       = 1'b0;
    clr_p    = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    dc       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE: if (start) next = S_LOAD;
      S_LOAD: begin
        ld    = 1'b1;
        clr_p = 1'b1;
        busy  = 1'b1;
        next  = S_TEST;
      end
      S_TEST: begin
        busy = 1'b1;
        if (cnt_done)     next = S_DONE;
        else if (overrun) next = S_DONE;
        else if (skip)    next = S_DONE;
        else if (q0)      next = S_ADD;
        else              next = S_SHIFT;
      end
      S_ADD: begin
        add_en = 1'b1;
        busy   = 1'b1;
        next   = S_SHIFT;
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        dc       = 1'b1;
        busy     = 1'b1;
        next     = S_TEST;
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl: the bench plays the datapath and predicts strobe counts and done latency.
// Honours MULT_CTRL_SKIP_EN the same way the design does.
module tb_mult_ctrl;

  localparam int ITERS = 4;
  localparam int CW    = 3;
`ifdef MULT_CTRL_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, q0, cnt_done, b_zero;
  logic ld, clr_p, add_en, shift_en, dc, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  mult_ctrl #(.ITERS(ITERS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .q0(q0), .cnt_done(cnt_done), .b_zero(b_zero),
    .ld(ld), .clr_p(clr_p), .add_en(add_en), .shift_en(shift_en), .dc(dc),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ld"}, ld, 0);
    chk({tag, " clr_p"}, clr_p, 0);
    chk({tag, " add_en"}, add_en, 0);
    chk({tag, " shift_en"}, shift_en, 0);
    chk({tag, " dc"}, dc, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " err"}, err, 0);
  endtask

  // One full operation. The multiplier bit for iteration i is pat[i]; the bench's counter
  // raises cnt_done after ITERS shifts unless no_cnt models a stuck counter.
  task automatic run_op(input logic [7:0] pat, input bit no_cnt, input bit hold, input string tag);
    int         k, exp_add, exp_done, shifts, n_ld, n_add, n_sh, n_dc;
    logic [3:0] lo;
    lo = pat[3:0];
    k  = 0;
    if (no_cnt) k = ITERS + 1;
    else while (k < ITERS && !(SKIP && ((lo >> k) == 4'd0))) k++;
    exp_add = 0;
    for (int i = 0; i < k; i++) exp_add += int'(pat[i]);
    // LOAD, then TEST(+ADD)+SHIFT per iteration, a final TEST, then DONE.
    exp_done = 3 + 2 * k + exp_add;

    shifts = 0; n_ld = 0; n_add = 0; n_sh = 0; n_dc = 0;
    start    = 1'b1;
    q0       = pat[0];
    cnt_done = 1'b0;
    b_zero   = no_cnt ? 1'b0 : (lo == 4'd0);
    for (int cyc = 1; cyc <= exp_done; cyc++) begin
      cycle();
      chk($sformatf("%s c%0d ld", tag, cyc), ld, int'(cyc == 1));
      chk($sformatf("%s c%0d clr_p", tag, cyc), clr_p, int'(cyc == 1));
      chk($sformatf("%s c%0d busy", tag, cyc), busy, int'(cyc < exp_done));
      chk($sformatf("%s c%0d done", tag, cyc), done, int'(cyc == exp_done));
      chk($sformatf("%s c%0d err", tag, cyc), err, (cyc == exp_done) ? int'(no_cnt) : 0);
      chk($sformatf("%s c%0d dc=shift", tag, cyc), dc, int'(shift_en));
      chk($sformatf("%s c%0d onehot", tag, cyc), int'(ld + add_en + shift_en <= 2'd1), 1);
      n_ld  += int'(ld);
      n_add += int'(add_en);
      n_sh  += int'(shift_en);
      n_dc  += int'(dc);
      shifts += int'(shift_en);
      if (ld || add_en || shift_en) begin
        // Inputs outside TEST must not matter: scramble them.
        q0       = 1'($urandom);
        cnt_done = 1'($urandom);
        b_zero   = 1'($urandom);
      end else begin
        q0       = pat[shifts];
        cnt_done = !no_cnt && (shifts >= ITERS);
        b_zero   = no_cnt ? 1'b0 : ((lo >> shifts) == 4'd0);
      end
      start = hold ? 1'b1 : ((cyc < exp_done) ? 1'($urandom) : 1'b0);
    end
    chk({tag, " ld count"}, n_ld, 1);
    chk({tag, " add count"}, n_add, exp_add);
    chk({tag, " shift count"}, n_sh, k);
    chk({tag, " dc count"}, n_dc, k);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        cycle();
        chk($sformatf("%s hold%0d done", tag, i), done, 1);
        chk($sformatf("%s hold%0d ld", tag, i), ld, 0);
        chk($sformatf("%s hold%0d busy", tag, i), busy, 0);
      end
      start = 1'b0;
    end
    cycle();
    chk({tag, " idle done"}, done, 0);
    chk({tag, " idle busy"}, busy, 0);
    chk({tag, " idle ld"}, ld, 0);
    chk({tag, " idle err"}, err, int'(no_cnt));
  endtask

  initial begin
    logic [7:0] pat;
    bit         reached;
    rst = 1'b1; start = 1'b0; q0 = 1'b0; cnt_done = 1'b0; b_zero = 1'b0;
    @(negedge clk);
    cycle();
    chk_all_zero("reset");
    rst = 1'b0;
    cycle();
    chk_all_zero("idle");

    run_op(8'h0F, 1'b0, 1'b0, "all_ones");
    run_op(8'h00, 1'b0, 1'b0, "all_zeros");
    run_op(8'h05, 1'b0, 1'b0, "alt_1010");

    pat = 8'($urandom);
    run_op(pat, 1'b1, 1'b0, "overrun");
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("err sticky idle%0d", i), err, 1);
    end
    run_op(8'($urandom), 1'b0, 1'b0, "after_err");
    run_op(8'($urandom), 1'b0, 1'b1, "hold_start");
    for (int n = 0; n < 6; n++) run_op(8'($urandom), 1'b0, 1'b0, $sformatf("rand%0d", n));

    // Reset while in ADD, then reset priority over a held start.
    start = 1'b1; q0 = 1'b1; cnt_done = 1'b0; b_zero = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      cycle();
      start   = 1'b0;
      reached = add_en;
    end
    chk("reach ADD", int'(reached), 1);
    rst = 1'b1; start = 1'b1;
    cycle();
    chk_all_zero("rst in ADD");
    cycle();
    chk_all_zero("rst over start");
    rst = 1'b0;
    cycle();
    chk("load after rst", ld, 1);
    chk("load after rst busy", busy, 1);
    rst = 1'b1; start = 1'b0;
    cycle();
    rst = 1'b0;
    cycle();
    chk_all_zero("final idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 Parameter ITERS, default 4, SHALL set the expected shift iterations per operation.
REQ-002 Parameter CW, default 3, SHALL set the shadow iteration counter width; CW SHALL hold ITERS+1.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  operation request, level; also the done-acknowledge.
REQ-006 q0  input  1  multiplier-register LSB from the datapath.
REQ-007 cnt_done  input  1  iteration counter terminal flag (counter "count" output).
REQ-008 b_zero  input  1  remaining multiplier bits all zero.
REQ-009 ld  output  1  load operand registers.
REQ-010 clr_p  output  1  clear product register.
REQ-011 add_en  output  1  accumulate multiplicand into product.
REQ-012 shift_en  output  1  shift product/multiplier right by one.
REQ-013 dc  output  1  advance the iteration counter by one.
REQ-014 busy  output  1  operation in progress.
REQ-015 done  output  1  result valid.
REQ-016 err  output  1  sticky iteration-overrun flag.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, TEST, ADD, SHIFT, DONE; all outputs SHALL be Moore decodes of the registered state, plus err.
REQ-018 IDLE: all strobes 0, busy 0, done 0; start=1 -> LOAD; else stay.
REQ-019 LOAD: one cycle, ld=1, clr_p=1, busy=1; shadow counter cleared; err cleared -> TEST.
REQ-020 TEST: busy=1, no strobes; priority cnt_done=1 -> DONE; else q0=1 -> ADD; else -> SHIFT.
REQ-021 ADD: one cycle, add_en=1, busy=1 -> SHIFT.
REQ-022 SHIFT: one cycle, shift_en=1, dc=1, busy=1; shadow counter +1 (saturating at 2^CW-1) -> TEST.
REQ-023 If the shadow counter equals ITERS+1 on entry to TEST and cnt_done=0, the FSM SHALL set err=1 and go to DONE.
REQ-024 DONE: done=1, busy=0; stay while start=1; start=0 -> IDLE.
REQ-025 err SHALL hold its value through DONE and IDLE until the next LOAD or reset.
REQ-026 start SHALL be ignored in LOAD, TEST, ADD and SHIFT; cnt_done SHALL be ignored outside TEST.
REQ-027 At most one of ld, add_en, shift_en SHALL be 1 in any cycle; dc SHALL equal shift_en.
REQ-028 Latency, ITERS=4, start sampled at edge 0: LOAD in cycle 1; all q0=1 -> done first high in cycle 15; all q0=0 -> cycle 11.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, clear the shadow counter, drive all outputs 0 including err, in any state.
REQ-030 rst SHALL take priority over start; with start held 1 after rst falls, LOAD SHALL follow one cycle later.

Configuration
REQ-031 With MULT_CTRL_SKIP_EN defined, TEST with cnt_done=0 and b_zero=1 SHALL go to DONE (early termination, err unchanged); cnt_done keeps priority.
REQ-032 Without MULT_CTRL_SKIP_EN, b_zero SHALL be present but ignored; behaviour is exactly REQ-020.

Verification
REQ-033 ITERS=4, q0=1 every TEST, cnt_done after 4th dc -> 4 add_en, 4 shift_en/dc pulses, done high in cycle 15, err=0.
REQ-034 q0 pattern 1,0,1,0 -> add_en only in iterations 1 and 3, done high in cycle 13.
REQ-035 cnt_done held 0 -> 5 dc pulses, then DONE with err=1; err stays 1 in IDLE until next LOAD clears it.
REQ-036 start held 1 through DONE for 5 cycles -> done stays 1, no LOAD; start=0 -> IDLE next edge, done=0.
REQ-037 rst=1 in ADD -> IDLE and all outputs 0 next edge; with MULT_CTRL_SKIP_EN, b_zero=1 at first TEST -> DONE in cycle 3, zero dc pulses.
